chaos_config_shifter: RTL and testbench

Serial configuration loader that sits directly upstream of the chaos automaton cell array. It accepts 32-bit configuration words from the management-side interface (Wishbone/LA glue), serialises them MSB-first into the array's configuration shift chain with a generated shift clock, and pulses a latch after the programmed word count. It also drives a 16-bit status code intended for the user GPIO status pins (mprj_io[31:16]), so a chip-level bench can track load progress.

---
 rtl/chaos_pkg.sv | 33 +++
 rtl/chaos_clk_phase_counter.sv | 34 +++
 rtl/chaos_config_shifter.sv | 131 +++++++++++++
 tb/tb_chaos_config_shifter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/chaos_pkg.sv
// Shared definitions for the chaos configuration loader.
// Provides the word width, the loader state encoding and the GPIO status
// codes, plus a helper that maps a state to its status code.
package chaos_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [15:0] STATUS_IDLE  = 16'hAB00;
  localparam logic [15:0] STATUS_WAIT  = 16'hAB40;
  localparam logic [15:0] STATUS_SHIFT = 16'hAB41;
  localparam logic [15:0] STATUS_LATCH = 16'hAB51;

  function automatic logic [15:0] status_code(input state_t s);
    logic [15:0] code;
    case (s)
      ST_WAIT:                  code = STATUS_WAIT;
      ST_SHIFT_LO, ST_SHIFT_HI: code = STATUS_SHIFT;
      ST_LATCH, ST_DONE:        code = STATUS_LATCH;
      default:                  code = STATUS_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/chaos_clk_phase_counter.sv
// Shift-clock phase timer.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   load   - hold the timer at the start of a phase
//   expire - high on the last cycle of a CLK_DIV-cycle phase
// While not loaded the timer counts down and reloads itself on expiry, so
// consecutive phases each last exactly CLK_DIV cycles.
module chaos_clk_phase_counter #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign expire = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (load || expire) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/chaos_config_shifter.sv
// Serial configuration loader for the chaos automaton cell array.
// Accepts 32-bit words, shifts them MSB-first into the configuration chain
// with a generated shift clock, and pulses latch after CHAIN_WORDS words.
// Ports:
//   wb_clk_i, wb_rst_i       - system clock, async active-high reset
//   start_i                  - begin/restart a load session (aborts any load)
//   data_i, valid_i, ready_o - word handshake (transfer on valid_i && ready_o)
//   shift_clk_o/data_o/en_o  - configuration chain interface
//   latch_o                  - one-cycle transfer pulse after the last word
//   busy_o, done_o           - session active / sticky load-complete
//   words_o                  - words shifted in this session
//   status_o                 - progress code for the GPIO status pins
// All outputs are registered.
module chaos_config_shifter
  import chaos_pkg::*;
#(
  parameter int CHAIN_WORDS = 4,
  parameter int CLK_DIV     = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              shift_clk_o,
  output logic              shift_data_o,
  output logic              shift_en_o,
  output logic              latch_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       words_o,
  output logic [15:0]       status_o
);

  localparam logic [15:0] LAST_WORD = 16'(CHAIN_WORDS);

  state_t            state, state_nx;
  logic [WORD_W-1:0] shreg, shreg_nx;
  logic [4:0]        bit_cnt;
  logic              phase_end, in_shift, phase_load;
  logic              accept, bit_step, shifting_nx;
  logic [15:0]       words_inc;

  assign in_shift    = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);
  assign phase_load  = !in_shift;
  assign accept      = (state == ST_WAIT) && valid_i && ready_o && !start_i;
  assign bit_step    = (state == ST_SHIFT_HI) && phase_end;
  assign words_inc   = (words_o == LAST_WORD) ? words_o : words_o + 16'd1;
  assign shifting_nx = (state_nx == ST_SHIFT_LO) || (state_nx == ST_SHIFT_HI);

  chaos_clk_phase_counter #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .load   (phase_load),
    .expire (phase_end)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start_i) begin
      state_nx = ST_WAIT;
    end else begin
      case (state)
        ST_WAIT:     if (accept) state_nx = ST_SHIFT_LO;
        ST_SHIFT_LO: if (phase_end) state_nx = ST_SHIFT_HI;
        ST_SHIFT_HI: begin
          if (phase_end) begin
            if (bit_cnt != '1)            state_nx = ST_SHIFT_LO;
            else if (words_inc == LAST_WORD) state_nx = ST_LATCH;
            else                          state_nx = ST_WAIT;
          end
        end
        ST_LATCH:    state_nx = ST_DONE;
        default:     state_nx = state;
      endcase
    end
  end

  always_comb begin
    shreg_nx = shreg;
    if (accept)        shreg_nx = data_i;
    else if (bit_step) shreg_nx = {shreg[WORD_W-2:0], 1'b0};
  end

  // Chain outputs are registered from the next state so they line up with
  // the state itself; shift_data_o follows the MSB of the next shift
  // register value, so it only moves on a LO-phase entry.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      ready_o      <= 1'b0;
      shift_clk_o  <= 1'b0;
      shift_data_o <= 1'b0;
      shift_en_o   <= 1'b0;
      latch_o      <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      words_o      <= '0;
      status_o     <= STATUS_IDLE;
    end else begin
      shreg        <= shreg_nx;
      shift_en_o   <= shifting_nx;
      shift_clk_o  <= (state_nx == ST_SHIFT_HI);
      shift_data_o <= shifting_nx ? shreg_nx[WORD_W-1] : 1'b0;
      latch_o      <= (state_nx == ST_LATCH);
      busy_o       <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
      status_o     <= status_code(state);
      // ready rises one cycle after WAIT is entered and drops on handshake.
      ready_o      <= (state == ST_WAIT) && (state_nx == ST_WAIT) && !start_i;

      if (accept)        bit_cnt <= '0;
      else if (bit_step) bit_cnt <= bit_cnt + 5'd1;

      if (start_i) begin
        words_o <= '0;
        done_o  <= 1'b0;
      end else begin
        if (bit_step && (bit_cnt == '1)) words_o <= words_inc;
        if (state_nx == ST_DONE)         done_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chaos_config_shifter.sv
module tb_chaos_config_shifter;
  import chaos_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  start, valid, ready, sclk, sdat, en, latch, busy, done;
  logic [31:0] data   [3];
  logic [15:0] words  [3];
  logic [15:0] status [3];
  logic [31:0] wtab   [4];

  int checks = 0;
  int errors = 0;

  // Instance 0: CHAIN_WORDS=4, CLK_DIV=2; 1: (1,1); 2: (1,3)
  for (genvar g = 0; g < 3; g++) begin : dut
    chaos_config_shifter #(
      .CHAIN_WORDS(g == 0 ? 4 : 1),
      .CLK_DIV    (g == 0 ? 2 : (g == 1 ? 1 : 3))
    ) u_dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .start_i      (start[g]),
      .data_i       (data[g]),
      .valid_i      (valid[g]),
      .ready_o      (ready[g]),
      .shift_clk_o  (sclk[g]),
      .shift_data_o (sdat[g]),
      .shift_en_o   (en[g]),
      .latch_o      (latch[g]),
      .busy_o       (busy[g]),
      .done_o       (done[g]),
      .words_o      (words[g]),
      .status_o     (status[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [38:0] outs(input int g);
    return {ready[g], busy[g], done[g], en[g], sclk[g], sdat[g], latch[g], words[g], status[g]};
  endfunction

  function automatic logic [38:0] ex(input logic r, b, d, e, c, s, l,
                                     input logic [15:0] w, input logic [15:0] st);
    return {r, b, d, e, c, s, l, w, st};
  endfunction

  // Chain monitor: counts shift-clock edges, collects bits, checks timing.
  for (genvar g = 0; g < 3; g++) begin : mon
    localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    int rises = 0, latches = 0, lo_cnt = 0, hi_cnt = 0, stable = 0;
    logic [31:0] cap = '0;
    logic prev_clk = 1'b0, prev_dat = 1'b0, rise_bit = 1'b0, held = 1'b1, st;
    always @(posedge clk) begin
      st = start[g];
      #1;
      if (rst) begin
        rises = 0; latches = 0; cap = '0; lo_cnt = 0; hi_cnt = 0;
        stable = 0; prev_clk = 1'b0; prev_dat = 1'b0;
      end else begin
        if (st) begin rises = 0; latches = 0; cap = '0; end
        if (latch[g]) latches++;
        stable = (sdat[g] == prev_dat) ? stable + 1 : 1;
        if (sclk[g] && !prev_clk) begin
          check($sformatf("setup%0d", g), 64'(stable - 1 >= D), 64'd1);
          check($sformatf("lo_len%0d", g), 64'(lo_cnt), 64'(D));
          rises++;
          cap = {cap[30:0], sdat[g]};
          rise_bit = sdat[g]; held = 1'b1; hi_cnt = 0;
        end
        if (sclk[g]) begin
          hi_cnt++; lo_cnt = 0;
          if (sdat[g] != rise_bit) held = 1'b0;
        end else begin
          if (prev_clk && !st) begin
            check($sformatf("hi_len%0d", g), 64'(hi_cnt), 64'(D));
            check($sformatf("hold%0d", g), 64'(held), 64'd1);
          end
          lo_cnt = en[g] ? lo_cnt + 1 : 0;
        end
        prev_clk = sclk[g]; prev_dat = sdat[g];
      end
    end
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic [38:0] exp;
  } vec_t;
  vec_t vecs [10];

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  // Transfer wtab[k] into instance 0 and wait until it is fully shifted.
  task automatic one_word(input int k);
    int t, low;
    data[0] = wtab[k]; valid[0] = 1'b1;
    t = 0;
    while (!ready[0] && t < 50) begin @(negedge clk); t++; end
    check($sformatf("hs_ready%0d", k), 64'(ready[0]), 64'd1);
    @(negedge clk);
    low = 0;
    while (!ready[0] && !done[0] && low < 1000) begin low++; @(negedge clk); end
    check($sformatf("ready_low%0d", k), 64'(low), 64'd129);
    check($sformatf("word_bits%0d", k), 64'(mon[0].cap), 64'(wtab[k]));
    check($sformatf("rises%0d", k), 64'(mon[0].rises), 64'(32 * (k + 1)));
    check($sformatf("words%0d", k), 64'(words[0]), 64'(k + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; start = '0; valid = '0;
    for (int i = 0; i < 3; i++) data[i] = '0;
    wtab[0] = 32'hA500_0001; wtab[1] = 32'h3C3C_F00F;
    wtab[2] = 32'h8000_0001; wtab[3] = 32'h1234_5678;

    vecs[0] = '{1'b0, 1'b0, 32'h0,       ex(0,0,0,0,0,0,0, 16'd0, STATUS_IDLE)};
    vecs[1] = '{1'b1, 1'b0, 32'h0,       ex(0,1,0,0,0,0,0, 16'd0, STATUS_IDLE)};
    vecs[2] = '{1'b0, 1'b0, 32'h0,       ex(1,1,0,0,0,0,0, 16'd0, STATUS_WAIT)};
    vecs[3] = '{1'b0, 1'b1, wtab[0],     ex(0,1,0,1,0,1,0, 16'd0, STATUS_WAIT)};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, ex(0,1,0,1,0,1,0, 16'd0, STATUS_SHIFT)};
    vecs[5] = '{1'b0, 1'b0, 32'h0,       ex(0,1,0,1,1,1,0, 16'd0, STATUS_SHIFT)};
    vecs[6] = '{1'b0, 1'b0, 32'h0,       ex(0,1,0,1,1,1,0, 16'd0, STATUS_SHIFT)};
    vecs[7] = '{1'b0, 1'b0, 32'h0,       ex(0,1,0,1,0,0,0, 16'd0, STATUS_SHIFT)};
    vecs[8] = '{1'b1, 1'b0, 32'h0,       ex(0,1,0,0,0,0,0, 16'd0, STATUS_SHIFT)};
    vecs[9] = '{1'b0, 1'b0, 32'h0,       ex(1,1,0,0,0,0,0, 16'd0, STATUS_WAIT)};

    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++)
      check($sformatf("reset%0d", g), 64'(outs(g)), 64'(ex(0,0,0,0,0,0,0, 16'd0, STATUS_IDLE)));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      start[0] = vecs[i].start; valid[0] = vecs[i].valid; data[0] = vecs[i].data;
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(outs(0)), 64'(vecs[i].exp));
    end
    start[0] = 1'b0; valid[0] = 1'b0;

    // Full four-word load with valid held high throughout, including DONE.
    pulse_start(0);
    for (int k = 0; k < 4; k++) one_word(k);
    repeat (20) @(negedge clk);
    check("full_final", 64'(outs(0)), 64'(ex(0,0,1,0,0,0,0, 16'd4, STATUS_LATCH)));
    check("full_latches", 64'(mon[0].latches), 64'd1);
    check("full_rises", 64'(mon[0].rises), 64'd128);
    valid[0] = 1'b0;

    // Abort at bit 10 of the second word, then a clean reload.
    pulse_start(0);
    one_word(0);
    data[0] = wtab[1];
    t = 0;
    while (mon[0].rises < 42 && t < 500) begin @(negedge clk); t++; end
    check("abort_reach", 64'(mon[0].rises), 64'd42);
    valid[0] = 1'b0;
    pulse_start(0);
    check("abort_now", 64'(outs(0)), 64'(ex(0,1,0,0,0,0,0, 16'd0, STATUS_SHIFT)));
    @(negedge clk);
    check("abort_wait", 64'(outs(0)), 64'(ex(1,1,0,0,0,0,0, 16'd0, STATUS_WAIT)));
    for (int k = 0; k < 4; k++) one_word(k);
    @(negedge clk);
    check("reload_final", 64'(outs(0)), 64'(ex(0,0,1,0,0,0,0, 16'd4, STATUS_LATCH)));
    check("reload_latches", 64'(mon[0].latches), 64'd1);
    valid[0] = 1'b0;

    // Asynchronous reset while the shift clock is high.
    pulse_start(0);
    one_word(0);
    data[0] = wtab[1];
    t = 0;
    while (!(sclk[0] && mon[0].rises > 40) && t < 500) begin @(negedge clk); t++; end
    check("rst_in_hi", 64'(sclk[0]), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid", 64'(outs(0)), 64'(ex(0,0,0,0,0,0,0, 16'd0, STATUS_IDLE)));
    @(negedge clk);
    rst = 1'b0; valid[0] = 1'b0;
    @(negedge clk);

    // Single-word loads at CLK_DIV=1 and CLK_DIV=3.
    start[1] = 1'b1; start[2] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0; start[2] = 1'b0;
    data[1] = wtab[1]; data[2] = wtab[2];
    valid[1] = 1'b1; valid[2] = 1'b1;
    t = 0;
    while (!(done[1] && done[2]) && t < 600) begin @(negedge clk); t++; end
    check("cw1_done", 64'({done[1], done[2]}), 64'd3);
    check("div1_bits", 64'(mon[1].cap), 64'(wtab[1]));
    check("div3_bits", 64'(mon[2].cap), 64'(wtab[2]));
    check("div1_rises", 64'(mon[1].rises), 64'd32);
    check("div3_rises", 64'(mon[2].rises), 64'd32);
    check("div1_latches", 64'(mon[1].latches), 64'd1);
    check("div3_latches", 64'(mon[2].latches), 64'd1);
    check("div1_final", 64'(outs(1)), 64'(ex(0,0,1,0,0,0,0, 16'd1, STATUS_LATCH)));
    check("div3_final", 64'(outs(2)), 64'(ex(0,0,1,0,0,0,0, 16'd1, STATUS_LATCH)));
    valid[1] = 1'b0; valid[2] = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
